// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared ALU definitions for the sequential divider
// Purpose : state encodings and default datapath width, shared with the
//           multiplier and future ALU control.
// Ports   : none (package)
package seq_divider_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - request/result bundle between ALU control and divider
// Purpose : groups the start/busy/done handshake with operands and results.
// Signals : start, dividend, divisor          (control -> divider)
//           quotient, remainder, busy, done, div_zero (divider -> control)
// Modports: master = ALU control side, slave = divider side.
interface seq_divider_if
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one restoring-division step (combinational)
// Purpose : shifts the next dividend bit into the partial remainder and
//           subtracts the divisor when it fits.
// Ports   : p_i      partial remainder in (always < d_i)
//           a_msb_i  next dividend bit shifted in
//           d_i      divisor
//           p_o      partial remainder out
//           q_bit_o  quotient bit produced by this step
module seq_divider_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic             a_msb_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] p_o,
  output logic             q_bit_o
);

  // One extra bit keeps the compare exact when the divisor has its MSB set.
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted = {p_i, a_msb_i};
    q_bit_o = (shifted >= {1'b0, d_i});
    // When the subtraction happens the result is < d_i, so the low bits
    // of a modular subtraction are exact.
    diff    = shifted[WIDTH-1:0] - d_i;
    p_o     = q_bit_o ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring unsigned divider, one bit per clock
// Purpose : computes quotient and remainder in WIDTH cycles; divide-by-zero
//           finishes immediately with quotient all ones, remainder = dividend.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    seq_divider_if.slave (start/operands in, results/handshake out)
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0]   p_q, p_d;     // partial remainder
  logic [WIDTH-1:0]   d_q, d_d;     // captured divisor
  logic [WIDTH-1:0]   quot_q, quot_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dz_q, dz_d;

  logic [WIDTH-1:0]   step_p;
  logic               step_q_bit;

  seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .p_i     (p_q),
    .a_msb_i (a_q[WIDTH-1]),
    .d_i     (d_q),
    .p_o     (step_p),
    .q_bit_o (step_q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      p_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      p_q     <= p_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    p_d     = p_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d   = bus.dividend;
          p_d   = '0;
          d_d   = bus.divisor;
          cnt_d = CNT_W'(WIDTH - 1);
          if (bus.divisor == '0) begin
            // Results are loaded on entry to FIN so they are valid with done.
            quot_d  = '1;
            rem_d   = bus.dividend;
            dz_d    = 1'b1;
            state_d = ST_FIN;
          end else begin
            dz_d    = 1'b0;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        a_d = {a_q[WIDTH-2:0], step_q_bit};
        p_d = step_p;
        if (cnt_q == '0) begin
          quot_d  = {a_q[WIDTH-2:0], step_q_bit};
          rem_d   = step_p;
          state_d = ST_FIN;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.div_zero  = dz_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_FIN);

endmodule
